// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and defaults for the UART TX packet arbiter (and the serial bus arbiters that reuse rr_pick).
// Holds the FSM state encoding, default parameters and the baud-rate constants shared with uart_tx.
package uart_tx_arbiter_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARB   = 3'd1,
        LOAD  = 3'd2,
        BUSY  = 3'd3,
        DRAIN = 3'd4
    } arb_state_e;

    localparam int unsigned DEF_NREQ        = 4;
    localparam int unsigned DEF_TIMEOUT_CYC = 2500;
    localparam int unsigned TIMEOUT_CNT_W   = 28;

    localparam int unsigned CLK_HZ  = 50_000_000;
    localparam int unsigned B9600   = 9600;
    localparam int unsigned B19200  = 19200;
    localparam int unsigned B57600  = 57600;
    localparam int unsigned B115200 = 115200;

    // Rounded clock divider for a given baud rate.
    function automatic int unsigned baud_div(input int unsigned baud);
        return (CLK_HZ + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// rr_pick: combinational round-robin search. Returns the first set req bit at or after ptr,
// wrapping from NREQ-1 back to 0, plus a flag that any request is present.
module rr_pick #(
    parameter  int unsigned NREQ = 4,
    localparam int unsigned PW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [PW-1:0]   winner,
    output logic            any
);

    always_comb begin
        int unsigned k;
        k      = 0;
        winner = '0;
        any    = 1'b0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            k = (32'(ptr) + i) % NREQ;
            if (!any && req[k[PW-1:0]]) begin
                any    = 1'b1;
                winner = k[PW-1:0];
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: packet-level round-robin sharing of one uart_tx among NREQ sources.
// Optional stalled-owner release is built only when UART_ARB_TIMEOUT_EN is defined.
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int unsigned NREQ        = DEF_NREQ,
    parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ-1:0]   valid,
    input  logic [8*NREQ-1:0] data,
    input  logic [NREQ-1:0]   last,
    output logic [NREQ-1:0]   accept,
    output logic [NREQ-1:0]   gnt,
    output logic [7:0]        tx_data,
    output logic              tx_start,
    input  logic              tx_ready,
    output logic              timeout
);

    localparam int unsigned PW = $clog2(NREQ);

    if (NREQ < 2 || NREQ > 8 || TIMEOUT_CYC == 0) begin : g_cfg_check
        $error("uart_tx_arbiter: NREQ must be 2..8 and TIMEOUT_CYC nonzero");
    end

    arb_state_e      state_q, state_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [NREQ-1:0] accept_q, accept_d;
    logic [PW-1:0]   own_q, own_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [7:0]      tx_data_q, tx_data_d;
    logic            tx_start_q, tx_start_d;
    logic            is_last_q, is_last_d;
    logic            timeout_q, timeout_d;
`ifdef UART_ARB_TIMEOUT_EN
    logic [TIMEOUT_CNT_W-1:0] cnt_q, cnt_d;
`endif

    logic [PW-1:0] pick_idx;
    logic          pick_any;
    logic          own_req, own_valid, own_last;
    logic [7:0]    own_byte;

    rr_pick #(.NREQ(NREQ)) u_pick (
        .req    (req),
        .ptr    (ptr_q),
        .winner (pick_idx),
        .any    (pick_any)
    );

    // Only the current owner's lane is ever observed.
    always_comb begin
        own_req   = 1'b0;
        own_valid = 1'b0;
        own_last  = 1'b0;
        own_byte  = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (own_q == PW'(i)) begin
                own_req   = req[i];
                own_valid = valid[i];
                own_last  = last[i];
                own_byte  = data[8*i +: 8];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        own_d      = own_q;
        ptr_d      = ptr_q;
        tx_data_d  = tx_data_q;
        tx_start_d = 1'b0;
        accept_d   = '0;
        is_last_d  = is_last_q;
        timeout_d  = 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
        cnt_d      = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (|req) state_d = ARB;
            end
            ARB: begin
                if (pick_any) begin
                    gnt_d           = '0;
                    gnt_d[pick_idx] = 1'b1;
                    own_d           = pick_idx;
                    ptr_d           = (pick_idx == PW'(NREQ - 1)) ? '0 : pick_idx + 1'b1;
                    state_d         = LOAD;
`ifdef UART_ARB_TIMEOUT_EN
                    cnt_d           = '0;
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            LOAD: begin
                if (!own_req) begin
                    gnt_d   = '0;
                    state_d = IDLE;
                end else if (own_valid && tx_ready) begin
                    tx_data_d       = own_byte;
                    tx_start_d      = 1'b1;
                    accept_d[own_q] = 1'b1;
                    is_last_d       = own_last;
                    state_d         = BUSY;
                end
`ifdef UART_ARB_TIMEOUT_EN
                else if (!own_valid) begin
                    if (cnt_q == TIMEOUT_CNT_W'(TIMEOUT_CYC - 1)) begin
                        gnt_d     = '0;
                        timeout_d = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
`endif
            end
            BUSY: begin
                if (!tx_ready) state_d = DRAIN;
            end
            DRAIN: begin
                if (tx_ready) begin
                    if (is_last_q) begin
                        gnt_d   = '0;
                        state_d = IDLE;
                    end else begin
                        state_d = LOAD;
`ifdef UART_ARB_TIMEOUT_EN
                        cnt_d   = '0;
`endif
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            gnt_q      <= '0;
            accept_q   <= '0;
            own_q      <= '0;
            ptr_q      <= '0;
            tx_data_q  <= 8'h00;
            tx_start_q <= 1'b0;
            is_last_q  <= 1'b0;
            timeout_q  <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
            cnt_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            accept_q   <= accept_d;
            own_q      <= own_d;
            ptr_q      <= ptr_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
            is_last_q  <= is_last_d;
            timeout_q  <= timeout_d;
`ifdef UART_ARB_TIMEOUT_EN
            cnt_q      <= cnt_d;
`endif
        end
    end

    assign gnt      = gnt_q;
    assign accept   = accept_q;
    assign tx_data  = tx_data_q;
    assign tx_start = tx_start_q;
    assign timeout  = timeout_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a behavioural uart_tx (ready low 10 cycles, from 1 cycle after start).
// Expectations for the timeout case follow UART_ARB_TIMEOUT_EN.
module tb_uart_tx_arbiter;

    localparam int NREQ = 4;
    localparam int TO   = 2500;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req, valid, last;
    logic [31:0] data;
    logic [3:0]  accept, gnt;
    logic [7:0]  tx_data;
    logic        tx_start, tx_ready, timeout;

    always #5 clk = ~clk;

    int ucnt = 0;
    always @(posedge clk) begin
        if (tx_start === 1'b1) ucnt <= 10;
        else if (ucnt != 0)    ucnt <= ucnt - 1;
    end
    assign tx_ready = (ucnt == 0);

    uart_tx_arbiter #(.NREQ(NREQ), .TIMEOUT_CYC(TO)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .valid    (valid),
        .data     (data),
        .last     (last),
        .accept   (accept),
        .gnt      (gnt),
        .tx_data  (tx_data),
        .tx_start (tx_start),
        .tx_ready (tx_ready),
        .timeout  (timeout)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] pkt [4][3];
    int         len [4];
    int         sent [4];
    int         drop_after [4];
    logic [3:0] active, stall, extra_valid;

    logic [7:0] log_data [64];
    int         log_own [64];
    int         n_starts, bad_acc, unstable, to_cnt, to_tick, cyc;
    int         acc_cnt [4];
    logic [3:0] to_gnt;
    logic [7:0] last_tx;

    logic [7:0] e3a [8] = '{8'h10, 8'h11, 8'h20, 8'h21, 8'h30, 8'h31, 8'h40, 8'h41};
    logic [7:0] e3b [8] = '{8'h30, 8'h31, 8'h40, 8'h41, 8'h10, 8'h11, 8'h20, 8'h21};
    int         o3a [8] = '{0, 0, 1, 1, 2, 2, 3, 3};
    int         o3b [8] = '{2, 2, 3, 3, 0, 0, 1, 1};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int oh2idx(input logic [3:0] g);
        case (g)
            4'b0001: return 0;
            4'b0010: return 1;
            4'b0100: return 2;
            4'b1000: return 3;
            default: return -1;
        endcase
    endfunction

    task automatic drive();
        for (int i = 0; i < NREQ; i++) begin
            req[i]   = active[i];
            valid[i] = (active[i] && !stall[i]) || extra_valid[i];
            if (active[i]) begin
                data[8*i +: 8] = pkt[i][sent[i]];
                last[i]        = (sent[i] == len[i] - 1);
            end else begin
                data[8*i +: 8] = 8'(cyc * 7 + i);
                last[i]        = extra_valid[i];
            end
        end
    endtask

    task automatic clear_log();
        n_starts = 0; bad_acc = 0; unstable = 0; to_cnt = 0; to_tick = 0; to_gnt = '0;
        for (int i = 0; i < NREQ; i++) acc_cnt[i] = 0;
    endtask

    task automatic start_pkt(input int r, input int n, input logic [7:0] b0, input logic [7:0] b1,
                             input logic [7:0] b2, input int drop);
        pkt[r][0] = b0; pkt[r][1] = b1; pkt[r][2] = b2;
        len[r] = n; sent[r] = 0; drop_after[r] = drop;
        active[r] = 1'b1;
        drive();
    endtask

    // One cycle: observe outputs at the falling edge, then advance the requester scripts.
    task automatic tick();
        @(negedge clk);
        if (tx_start) begin
            if (n_starts < 64) begin
                log_data[n_starts] = tx_data;
                log_own[n_starts]  = oh2idx(gnt);
            end
            n_starts++;
            last_tx = tx_data;
        end else if (!tx_ready && tx_data !== last_tx) begin
            unstable++;
        end
        if ((accept & ~gnt) != 0) bad_acc++;
        if (timeout) begin
            to_cnt++;
            to_tick = cyc;
            to_gnt  = gnt;
        end
        for (int i = 0; i < NREQ; i++) begin
            if (accept[i]) acc_cnt[i]++;
            if (accept[i] && active[i]) begin
                sent[i]++;
                if (sent[i] == len[i] || (drop_after[i] > 0 && sent[i] == drop_after[i]))
                    active[i] = 1'b0;
            end
        end
        cyc++;
        drive();
    endtask

    task automatic run_until_idle(input string tag, input int budget);
        int k;
        k = 0;
        while (k < budget && !(active == 0 && gnt == 0 && tx_ready)) begin
            tick();
            k++;
        end
        check(tag, 32'(k < budget), 32'd1);
    endtask

    task automatic wait_gnt(input string tag, input logic [3:0] m, input int budget, output int t_seen);
        int k;
        k = 0;
        t_seen = 0;
        while (k < budget && gnt !== m) begin
            tick();
            k++;
        end
        t_seen = cyc - 1;
        check(tag, 32'(k < budget), 32'd1);
    endtask

    initial begin
        int t0;
        rst = 1'b0;
        active = '0; stall = '0; extra_valid = '0;
        cyc = 0; last_tx = 8'h00;
        for (int i = 0; i < NREQ; i++) begin
            len[i] = 1; sent[i] = 0; drop_after[i] = 0;
            for (int j = 0; j < 3; j++) pkt[i][j] = 8'h00;
        end
        drive();
        clear_log();

        // Power-on reset
        repeat (3) tick();
        check("por_gnt", gnt, 0);
        check("por_tx_start", tx_start, 0);
        check("por_accept", accept, 0);
        check("por_tx_data", tx_data, 8'h00);
        check("por_timeout", timeout, 0);
        rst = 1'b1;

        // Single requester, three-byte packet
        clear_log();
        start_pkt(0, 3, 8'h41, 8'h54, 8'h0D, 0);
        tick();
        check("t2_gnt_edge1", gnt, 4'b0000);
        tick();
        check("t2_gnt_edge2", gnt, 4'b0001);
        run_until_idle("t2_bound", 200);
        check("t2_starts", n_starts, 3);
        check("t2_byte0", log_data[0], 8'h41);
        check("t2_byte1", log_data[1], 8'h54);
        check("t2_byte2", log_data[2], 8'h0D);
        for (int j = 0; j < 3; j++) check($sformatf("t2_own%0d", j), log_own[j], 0);
        check("t2_accepts", acc_cnt[0], 3);
        check("t2_gnt_end", gnt, 0);

        // Single-byte packet on req3 wraps ptr back to 0
        clear_log();
        start_pkt(3, 1, 8'h5A, 8'h00, 8'h00, 0);
        run_until_idle("t3_prep0_bound", 100);
        check("t3_prep0_byte", log_data[0], 8'h5A);

        // All four request together from ptr=0
        clear_log();
        start_pkt(0, 2, 8'h10, 8'h11, 8'h00, 0);
        start_pkt(1, 2, 8'h20, 8'h21, 8'h00, 0);
        start_pkt(2, 2, 8'h30, 8'h31, 8'h00, 0);
        start_pkt(3, 2, 8'h40, 8'h41, 8'h00, 0);
        run_until_idle("t3a_bound", 600);
        check("t3a_starts", n_starts, 8);
        for (int j = 0; j < 8; j++) begin
            check($sformatf("t3a_byte%0d", j), log_data[j], e3a[j]);
            check($sformatf("t3a_own%0d", j), log_own[j], o3a[j]);
        end

        // Packet on req1 leaves ptr=2
        clear_log();
        start_pkt(1, 1, 8'h77, 8'h00, 8'h00, 0);
        run_until_idle("t3_prep2_bound", 100);
        check("t3_prep2_own", log_own[0], 1);

        clear_log();
        start_pkt(0, 2, 8'h10, 8'h11, 8'h00, 0);
        start_pkt(1, 2, 8'h20, 8'h21, 8'h00, 0);
        start_pkt(2, 2, 8'h30, 8'h31, 8'h00, 0);
        start_pkt(3, 2, 8'h40, 8'h41, 8'h00, 0);
        run_until_idle("t3b_bound", 600);
        check("t3b_starts", n_starts, 8);
        for (int j = 0; j < 8; j++) begin
            check($sformatf("t3b_byte%0d", j), log_data[j], e3b[j]);
            check($sformatf("t3b_own%0d", j), log_own[j], o3b[j]);
        end

        // Owner req1 abandons after its first byte; req2 waits for the boundary
        clear_log();
        start_pkt(1, 3, 8'hA1, 8'hA2, 8'hA3, 1);
        wait_gnt("t4_gnt1_bound", 4'b0010, 20, t0);
        start_pkt(2, 1, 8'hB1, 8'h00, 8'h00, 0);
        run_until_idle("t4_bound", 200);
        check("t4_starts", n_starts, 2);
        check("t4_byte0", log_data[0], 8'hA1);
        check("t4_own0", log_own[0], 1);
        check("t4_byte1", log_data[1], 8'hB1);
        check("t4_own1", log_own[1], 2);
        check("t4_acc1", acc_cnt[1], 1);
        check("t4_acc2", acc_cnt[2], 1);

        // Non-owners assert valid with changing data during a packet
        clear_log();
        extra_valid = 4'b1010;
        start_pkt(0, 3, 8'hC1, 8'hC2, 8'hC3, 0);
        run_until_idle("t6_bound", 200);
        extra_valid = '0;
        drive();
        check("t6_starts", n_starts, 3);
        check("t6_byte2", log_data[2], 8'hC3);
        check("t6_acc1", acc_cnt[1], 0);
        check("t6_acc3", acc_cnt[3], 0);
        check("t6_bad_acc", bad_acc, 0);
        check("t6_tx_data_stable", unstable, 0);

        // Owner stalls with valid low
        clear_log();
        stall[2] = 1'b1;
        start_pkt(2, 1, 8'hD1, 8'h00, 8'h00, 0);
        wait_gnt("t5_gnt_bound", 4'b0100, 20, t0);
        repeat (3000) tick();
`ifdef UART_ARB_TIMEOUT_EN
        check("t5_to_pulses", to_cnt, 1);
        check("t5_to_delay", 32'(to_tick - t0), 32'(TO));
        check("t5_to_gnt", to_gnt, 4'b0000);
`else
        check("t5_no_timeout", to_cnt, 0);
        check("t5_gnt_held", gnt, 4'b0100);
`endif
        check("t5_starts", n_starts, 0);
        active[2] = 1'b0;
        stall[2]  = 1'b0;
        drive();
        run_until_idle("t5_release_bound", 50);

        // Reset in the middle of a packet
        clear_log();
        start_pkt(0, 3, 8'hE1, 8'hE2, 8'hE3, 0);
        for (int k = 0; k < 50 && n_starts == 0; k++) tick();
        check("t1_first_start", n_starts, 1);
        repeat (2) tick();
        rst = 1'b0;
        active = '0;
        last_tx = 8'h00;
        drive();
        repeat (3) tick();
        check("t1_gnt", gnt, 0);
        check("t1_tx_start", tx_start, 0);
        check("t1_accept", accept, 0);
        check("t1_tx_data", tx_data, 8'h00);
        rst = 1'b1;
        clear_log();
        repeat (5) tick();
        check("t1_no_start_after", n_starts, 0);
        check("t1_gnt_after", gnt, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
